uart_link_tx_arbiter: RTL

//  Shares the single UART TX serializer of one board between two byte-frame sources:
//  - source 0: bus-bridge request frames (initiator side);
//  - source 1: bus-bridge response frames (target side).

---
 rtl/uart_link_pkg.sv | 19 +
 rtl/rr_pick2.sv | 22 ++
 rtl/uart_link_tx_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_link_pkg.sv
// Shared types for the UART link TX arbiter: FSM state encoding and source indices.
package uart_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        START,
        WAIT_HI,
        WAIT_LO
    } arb_state_t;

    localparam int SRC0 = 0;
    localparam int SRC1 = 1;

    function automatic logic [1:0] src_onehot(input logic src);
        return src ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: one-hot winner from two requests, favouring the source that did not own last.
// Purely combinational; no backpressure of its own.
module rr_pick2
    import uart_link_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_owner_i,
    output logic [1:0] pick_o
);

    always_comb begin
        pick_o = 2'b00;
        if (valid_i[SRC0] && valid_i[SRC1]) begin
            pick_o = src_onehot(!last_owner_i);
        end else if (valid_i[SRC0]) begin
            pick_o = src_onehot(1'b0);
        end else if (valid_i[SRC1]) begin
            pick_o = src_onehot(1'b1);
        end
    end

endmodule

// File: rtl/uart_link_tx_arbiter.sv
// Frame-atomic round-robin share of one UART TX between request (src0) and response (src1) frame builders.
// Accept -> tx_start is 1 cycle; sources are held off (ready=0) except in ACCEPT for the owner while TX is idle.
module uart_link_tx_arbiter
    import uart_link_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int BUSY_WAIT      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_valid,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s0_last,
    output logic              s0_ready,
    input  logic              s1_valid,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              s1_last,
    output logic              s1_ready,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    output logic [1:0]        grant,
    output logic              frame_done,
    output logic              timeout_err
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_WAIT - 1);

    arb_state_t        state_q;
    logic [1:0]        grant_q;
    logic              last_owner_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              last_q;
    logic              tx_start_q;
    logic              frame_done_q;
    logic              timeout_err_q;
    logic [TW-1:0]     tout_cnt_q;
    logic [BW-1:0]     busy_cnt_q;

    logic [1:0]        pick;
    logic              acc_en;
    logic              xfer;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic              sel_last;
    logic              owner;

    rr_pick2 u_pick (
        .valid_i      ({s1_valid, s0_valid}),
        .last_owner_i (last_owner_q),
        .pick_o       (pick)
    );

    // Ready only while the owner may hand a byte over and the serializer is free.
    assign acc_en    = (state_q == ACCEPT) && !tx_busy;
    assign s0_ready  = acc_en && grant_q[SRC0] && s0_valid;
    assign s1_ready  = acc_en && grant_q[SRC1] && s1_valid;
    assign xfer      = s0_ready || s1_ready;
    assign sel_valid = (grant_q[SRC0] && s0_valid) || (grant_q[SRC1] && s1_valid);
    assign sel_data  = grant_q[SRC1] ? s1_data : s0_data;
    assign sel_last  = grant_q[SRC1] ? s1_last : s0_last;
    assign owner     = grant_q[SRC1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= 2'b00;
            last_owner_q  <= 1'b1;
            tx_data_q     <= '0;
            last_q        <= 1'b0;
            tx_start_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            tout_cnt_q    <= '0;
            busy_cnt_q    <= '0;
        end else begin
            tx_start_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|pick) begin
                        grant_q <= pick;
                        state_q <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (xfer) begin
                        tx_data_q  <= sel_data;
                        last_q     <= sel_last;
                        tout_cnt_q <= '0;
                        tx_start_q <= 1'b1;
                        state_q    <= START;
                    end else if (tout_cnt_q == TOUT_LAST) begin
                        // Stalled owner loses its turn so the other source is favoured next.
                        timeout_err_q <= 1'b1;
                        grant_q       <= 2'b00;
                        last_owner_q  <= owner;
                        tout_cnt_q    <= '0;
                        state_q       <= IDLE;
                    end else if (!sel_valid) begin
                        tout_cnt_q <= tout_cnt_q + TW'(1);
                    end
                end
                START: begin
                    busy_cnt_q <= '0;
                    state_q    <= WAIT_HI;
                end
                WAIT_HI: begin
                    // A TX that never reports busy must not wedge the link.
                    if (tx_busy || busy_cnt_q == BUSY_LAST) begin
                        state_q <= WAIT_LO;
                    end else begin
                        busy_cnt_q <= busy_cnt_q + BW'(1);
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (last_q) begin
                            frame_done_q <= 1'b1;
                            last_owner_q <= owner;
                            grant_q      <= 2'b00;
                            state_q      <= IDLE;
                        end else begin
                            state_q <= ACCEPT;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant       = grant_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_err_q;

endmodule
